// File: rtl/office_pan_fetch.sv
// office_pan_fetch: upstream stage of the office palette lookup.
// Maps 2x-scaled VGA draw coordinates onto the 400x240 office image with a
// per-frame horizontal pan, issues the ROM address, registers the returned
// palette index and delays de/hs/vs so everything leaves aligned, 3 cycles
// after the coordinates arrive.
module office_pan_fetch #(
  parameter int IMG_W    = 400,
  parameter int IMG_H    = 240,
  parameter int VIS_W    = 320,
  parameter int PAN_STEP = 4,
  parameter int INIT_OFF = 40,
  parameter int ADDR_W   = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              de_i,
  input  logic              hs_i,
  input  logic              vs_i,
  input  logic              frame_start,
  input  logic              pan_left,
  input  logic              pan_right,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index_o,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [6:0]        pan_off
);

  localparam int MAX_OFF = IMG_W - VIS_W;

  typedef enum logic [1:0] {
    PAN_IDLE  = 2'd0,
    PAN_LEFT  = 2'd1,
    PAN_RIGHT = 2'd2
  } pan_state_t;

  pan_state_t  state, state_next;
  logic [6:0]  off_next;
  logic [7:0]  off_up;

  logic [8:0]  sx, sy;
  logic [31:0] addr_full;
  logic        in_image;
  logic [ADDR_W-1:0] addr_next;

  // Sync/enable delay taps: stage 1 and stage 2; stage 3 is the output register.
  logic de_p1, de_p2;
  logic hs_p1, hs_p2;
  logic vs_p1, vs_p2;

  // The 2x scale drops the coordinate LSBs; the address is truncated to ADDR_W.
  logic unused;
  assign unused = &{1'b0, draw_x[0], draw_y[0], addr_full[31:ADDR_W]};

  // Source-pixel address for the current draw position, including pan.
  always_comb begin
    sx        = draw_x[9:1];
    sy        = draw_y[9:1];
    addr_full = 32'(sy) * 32'(IMG_W) + 32'(sx) + 32'(pan_off);
    in_image  = de_i && (32'(sy) < 32'(IMG_H));
    addr_next = in_image ? addr_full[ADDR_W-1:0] : '0;
  end

  // Pan next-state and saturating offset; only a frame_start cycle can move it.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    off_next   = pan_off;
    off_up     = {1'b0, pan_off} + 8'(PAN_STEP);
    if (frame_start) begin
      unique case ({pan_left, pan_right})
        2'b10:   state_next = PAN_LEFT;
        2'b01:   state_next = PAN_RIGHT;
        default: state_next = PAN_IDLE;
      endcase
      unique case (state_next)
        PAN_LEFT:  off_next = (pan_off < 7'(PAN_STEP)) ? 7'd0 : pan_off - 7'(PAN_STEP);
        PAN_RIGHT: off_next = (off_up > 8'(MAX_OFF)) ? 7'(MAX_OFF) : off_up[6:0];
        default:   off_next = pan_off;
      endcase
    end
  end

  // Pan state and offset registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= PAN_IDLE;
      pan_off <= 7'(INIT_OFF);
    end else begin
      state   <= state_next;
      pan_off <= off_next;
    end
  end

  // Stage 1: ROM address plus first delay tap of the timing signals.
  // NOTE: every pipeline register is reset to its idle value (syncs idle high)
  // so the outputs are clean while the pipeline refills after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      de_p1    <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      rom_addr <= addr_next;
      de_p1    <= de_i;
      hs_p1    <= hs_i;
      vs_p1    <= vs_i;
    end
  end

  // Stage 2: timing signals wait out the ROM's one-cycle read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      de_p2 <= 1'b0;
      hs_p2 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      de_p2 <= de_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  // Stage 3: register the palette index (blanked outside the active area).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      index_o <= 4'h0;
      de_o    <= 1'b0;
      hs_o    <= 1'b1;
      vs_o    <= 1'b1;
    end else begin
      index_o <= de_p2 ? rom_q : 4'h0;
      de_o    <= de_p2;
      hs_o    <= hs_p2;
      vs_o    <= vs_p2;
    end
  end

endmodule

// File: tb/tb_office_pan_fetch.sv
// Scoreboard bench for office_pan_fetch: a driver pushes expected results
// computed from the coordinate/pan rules; a monitor pops and compares them
// when the DUT presents the matching output.
module tb_office_pan_fetch;

  localparam int IMG_W    = 400;
  localparam int IMG_H    = 240;
  localparam int VIS_W    = 320;
  localparam int PAN_STEP = 4;
  localparam int INIT_OFF = 40;
  localparam int ADDR_W   = 17;
  localparam int MAX_OFF  = IMG_W - VIS_W;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [9:0]        draw_x = '0;
  logic [9:0]        draw_y = '0;
  logic              de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b1;
  logic              frame_start = 1'b0, pan_left = 1'b0, pan_right = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q = 4'h0;
  logic [3:0]        index_o;
  logic              de_o, hs_o, vs_o;
  logic [6:0]        pan_off;

  office_pan_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .VIS_W(VIS_W), .PAN_STEP(PAN_STEP),
    .INIT_OFF(INIT_OFF), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .draw_x(draw_x), .draw_y(draw_y),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .frame_start(frame_start),
    .pan_left(pan_left), .pan_right(pan_right), .rom_addr(rom_addr),
    .rom_q(rom_q), .index_o(index_o), .de_o(de_o), .hs_o(hs_o),
    .vs_o(vs_o), .pan_off(pan_off)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Image ROM contents: address 40 holds 4'hA, the rest a scrambled pattern.
  function automatic logic [3:0] rom_fn(input int a);
    int h;
    if (a == 40) return 4'hA;
    h = a ^ (a >> 3) ^ (a >> 7) ^ 5;
    return h[3:0];
  endfunction

  // Synchronous one-cycle ROM.
  always @(posedge Clk) rom_q <= rom_fn(int'(rom_addr));

  typedef struct {int stamp; logic [3:0] idx; logic de; logic hs; logic vs;} out_t;
  typedef struct {int stamp; int addr; int pan;} addr_t;

  out_t  oq[$];
  addr_t aq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    pan_m = INIT_OFF;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs now and push the expected results.
  task automatic apply(input int x, input int y, input bit de, input bit hs,
                       input bit vs, input bit fs, input bit pl, input bit pr);
    int sx, sy, addr;
    out_t o;
    addr_t a;
    draw_x = 10'(x); draw_y = 10'(y);
    de_i = de; hs_i = hs; vs_i = vs;
    frame_start = fs; pan_left = pl; pan_right = pr;
    sx = x / 2;
    sy = y / 2;
    addr = (de && sy < IMG_H) ? (sy * IMG_W + sx + pan_m) % (1 << ADDR_W) : 0;
    o.stamp = cyc; o.idx = de ? rom_fn(addr) : 4'h0; o.de = de; o.hs = hs; o.vs = vs;
    oq.push_back(o);
    if (fs && pl && !pr) pan_m = (pan_m - PAN_STEP < 0) ? 0 : pan_m - PAN_STEP;
    else if (fs && pr && !pl) pan_m = (pan_m + PAN_STEP > MAX_OFF) ? MAX_OFF : pan_m + PAN_STEP;
    a.stamp = cyc; a.addr = addr; a.pan = pan_m;
    aq.push_back(a);
  endtask

  task automatic drive(input int x, input int y, input bit de, input bit hs,
                       input bit vs, input bit fs, input bit pl, input bit pr);
    @(negedge Clk);
    apply(x, y, de, hs, vs, fs, pl, pr);
  endtask

  task automatic reset_assert();
    @(negedge Clk);
    Reset_n = 1'b0;
    oq.delete();
    aq.delete();
    pan_m = INIT_OFF;
    #1;
    check("rst_index", index_o, 0);
    check("rst_de", de_o, 0);
    check("rst_hs", hs_o, 1);
    check("rst_vs", vs_o, 1);
    check("rst_pan", pan_off, INIT_OFF);
    check("rst_addr", rom_addr, 0);
  endtask

  // Release reset and present the first input in the same cycle; the idle
  // values still in the pipeline are expected until the input emerges.
  task automatic reset_release(input int x, input int y, input bit de);
    out_t o;
    addr_t a;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      o.stamp = cyc - k; o.idx = 4'h0; o.de = 1'b0; o.hs = 1'b1; o.vs = 1'b1;
      oq.push_back(o);
    end
    a.stamp = cyc - 1; a.addr = 0; a.pan = INIT_OFF;
    aq.push_back(a);
    apply(x, y, de, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare outputs as each expected result falls due.
  initial begin
    out_t  o;
    addr_t a;
    forever begin
      @(negedge Clk);
      #1;
      if (Reset_n) begin
        while (oq.size() > 0 && cyc >= oq[0].stamp + 3) begin
          o = oq.pop_front();
          check("index_o", index_o, o.idx);
          check("de_o", de_o, o.de);
          check("hs_o", hs_o, o.hs);
          check("vs_o", vs_o, o.vs);
        end
        while (aq.size() > 0 && cyc >= aq[0].stamp + 1) begin
          a = aq.pop_front();
          check("rom_addr", rom_addr, a.addr);
          check("pan_off", pan_off, a.pan);
        end
      end
    end
  end

  initial begin
    int x, y;
    bit de;
    reset_assert();
    repeat (2) @(negedge Clk);

    // Origin with centred pan: address 40, index 4'hA three cycles later.
    reset_release(0, 0, 1'b1);
    drive(639, 479, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // 95959
    drive(638, 478, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(100, 480, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // sy = 240: outside image
    drive(1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'b0,
            1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);

    // Pan right held: 44..80 then saturated; level between pulses changes nothing.
    for (int i = 0; i < 11; i++) begin
      drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(638, 200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    #2 check("pan_sat_hi", pan_off, MAX_OFF);

    // Pan left held for 21 pulses: reaches 0 and stays there.
    for (int i = 0; i < 21; i++) begin
      drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(20, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    #2 check("pan_sat_lo", pan_off, 0);

    // Move off zero, then both-high pulse and toggling between pulses.
    drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      drive(10, 20, 1'b1, 1'b1, 1'b1, 1'b0, 1'(i), 1'(i + 1));
    #2 check("pan_hold", pan_off, PAN_STEP);

    // Random traffic, including frame_start during active video.
    for (int i = 0; i < 400; i++) begin
      x  = $urandom_range(0, 799);
      y  = $urandom_range(0, 524);
      de = (x < 640) && (y < 480) && ($urandom_range(0, 3) != 0);
      drive(x, y, de, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of an active line with syncs low.
    for (int i = 0; i < 4; i++)
      drive(300 + i, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_assert();
    repeat (2) @(negedge Clk);
    reset_release(0, 0, 1'b0);
    drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(2 * i, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (5) drive(700, 500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge Clk);
    #2;
    check("drain_out", oq.size(), 0);
    check("drain_addr", aq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/office_pan_fetch.md
Name: office_pan_fetch

Overview:
- Upstream stage of the office palette lookup.
- Converts VGA draw coordinates into office-image ROM addresses, applying a horizontal pan offset. The offset lets the 400-pixel-wide office image scroll behind a 2x-scaled 640x480 display.
- Registers the 4-bit palette index returned by the ROM and delays the sync and enable signals, so index and timing arrive at the palette stage aligned.
- Updates the pan offset once per frame from camera-pan controls.

Parameters:
- IMG_W, 400, office image width in source pixels
- IMG_H, 240, office image height in source pixels
- VIS_W, 320, visible source width (640 screen pixels / 2)
- PAN_STEP, 4, source pixels moved per frame while a pan input is held
- INIT_OFF, 40, pan offset after reset (centred view)
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- draw_x  in  10  current screen column, 0..799
- draw_y  in  10  current screen row, 0..524
- de_i  in  1  display enable (active area) for draw_x/draw_y
- hs_i  in  1  hsync aligned with draw_x
- vs_i  in  1  vsync aligned with draw_x
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blank
- pan_left  in  1  level; request decreasing offset
- pan_right  in  1  level; request increasing offset
- rom_addr  out  ADDR_W  address to the office image ROM (synchronous, 1-cycle read)
- rom_q  in  4  ROM data, valid 1 cycle after rom_addr
- index_o  out  4  palette index to the palette stage
- de_o  out  1  de_i delayed to match index_o
- hs_o  out  1  hs_i delayed to match index_o
- vs_o  out  1  vs_i delayed to match index_o
- pan_off  out  7  current pan offset, 0..IMG_W-VIS_W

Behaviour:
- Reset (async assert, sync release): pan_off=INIT_OFF; rom_addr=0; index_o=0; de_o=0; hs_o=1; vs_o=1; all pipeline registers to these idle values.
- Stage 1 (cycle N+1):
  - sx = draw_x>>1, sy = draw_y>>1.
  - rom_addr <= sy*IMG_W + sx + pan_off, computed at full width then truncated to ADDR_W.
  - If de_i=0 or sy>=IMG_H, rom_addr <= 0.
  - de, hs and vs each enter a delay line.
- Stage 2 (cycle N+2): the ROM presents rom_q for the stage-1 address.
- Stage 3 (cycle N+3):
  - index_o <= rom_q if the delayed de is 1, else 0.
  - de_o, hs_o and vs_o are the inputs delayed exactly 3 cycles.
- Total latency, inputs to index_o/de_o/hs_o/vs_o: 3 cycles, constant, including across blanking.
- Pan state machine, states IDLE / LEFT / RIGHT, evaluated only on a frame_start cycle:
  - pan_left=1, pan_right=0: LEFT; pan_off <= max(pan_off-PAN_STEP, 0).
  - pan_right=1, pan_left=0: RIGHT; pan_off <= min(pan_off+PAN_STEP, IMG_W-VIS_W).
  - Both or neither high: IDLE; pan_off unchanged.
  - State is held until the next frame_start and is observable only through pan_off.
- pan_off never changes outside a frame_start cycle. This guarantees a tear-free frame.
- The new pan_off is first used by the stage-1 address on the cycle after frame_start.
- Saturation: at 0, pan_left leaves 0; at 80, pan_right leaves 80. Non-multiple steps clamp exactly, e.g. 78+4 gives 80.
- frame_start coinciding with de_i=1 is illegal upstream. The block still updates pan_off, and only addresses after that cycle use it.
- Reset mid-frame: outputs return immediately to the reset values; the pipeline refills after 3 cycles of valid input.

Test Plan:
- Reset released, draw_x=0, draw_y=0, de_i=1 → rom_addr=40 at cycle 1; with ROM preloaded addr40=4'hA, index_o=4'hA and de_o=1 at cycle 3.
- draw_x=639, draw_y=479, pan_off=40 → rom_addr=239*400+319+40=95959; hs_o/vs_o/de_o equal the inputs delayed exactly 3 cycles.
- de_i=0 with any coordinates → rom_addr=0; index_o=0 three cycles later.
- pan_right held for 11 frame_start pulses from 40 → offsets 44,48,…,80, then stays 80. pan_left held for 21 pulses → reaches 0 and stays 0.
- pan_left=pan_right=1 at frame_start → pan_off unchanged. Pan inputs toggled between pulses → no change until the next frame_start.
- Reset_n asserted mid-line → index_o=0, de_o=0, hs_o=1, vs_o=1 and pan_off=40 asynchronously. After release, first valid index_o appears 3 cycles after the first de_i=1.
